// File: rtl/jpeg_bit_unpacker.sv
// JPEG scan bitstream reader: removes 0xFF00 byte stuffing, stops on markers,
// and offers an MSB-aligned 16-bit window out of a 32-bit shift buffer.
module jpeg_bit_unpacker (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  input  logic [7:0]  in_data,
  output logic        in_ready,
  output logic [15:0] bits_window,
  output logic [5:0]  bits_avail,
  input  logic        consume,
  input  logic [4:0]  consume_len,
  input  logic        align,
  output logic        marker_valid,
  output logic [7:0]  marker_code,
  input  logic        marker_ack,
  output logic        err_underflow
);

  typedef enum logic [1:0] {
    S_DATA = 2'd0,
    S_FF   = 2'd1,
    S_MARK = 2'd2
  } state_t;

  state_t      state_r;
  logic [31:0] buf_r;
  logic [5:0]  cnt_r;
  logic        marker_valid_r;
  logic [7:0]  marker_code_r;
  logic        err_underflow_r;

  logic        accept_s;
  logic        cons_ok_s;
  logic [5:0]  cons_len_s;
  logic [31:0] buf_c_s;
  logic [5:0]  cnt_c_s;
  logic [5:0]  drop_s;
  logic [31:0] buf_a_s;
  logic [5:0]  cnt_a_s;
  logic        push_s;
  logic [7:0]  push_byte_s;
  logic [31:0] buf_n_s;
  logic [5:0]  cnt_n_s;

  // Readiness uses registered state only, so it never depends on this cycle's consume.
  assign in_ready = !rst && (state_r != S_MARK) && (cnt_r <= 6'd24);

  // Next buffer contents: consume first, then align, then append any accepted byte.
  always_comb begin
    accept_s   = in_valid && in_ready;
    cons_ok_s  = consume && ({1'b0, consume_len} <= cnt_r);
    cons_len_s = cons_ok_s ? {1'b0, consume_len} : 6'd0;
    buf_c_s    = buf_r << cons_len_s;
    cnt_c_s    = cnt_r - cons_len_s;
    if (align) begin
      drop_s = {3'd0, cnt_c_s[2:0]};
    end else begin
      drop_s = 6'd0;
    end
    buf_a_s     = buf_c_s << drop_s;
    cnt_a_s     = cnt_c_s - drop_s;
    push_s      = 1'b0;
    push_byte_s = 8'h00;
    if (accept_s) begin
      case (state_r)
        S_DATA: begin
          push_s      = (in_data != 8'hFF);
          push_byte_s = in_data;
        end
        S_FF: begin
          push_s      = (in_data == 8'h00);
          push_byte_s = 8'hFF;
        end
        default: begin
          push_s      = 1'b0;
          push_byte_s = 8'h00;
        end
      endcase
    end else begin
      push_s      = 1'b0;
      push_byte_s = 8'h00;
    end
    // Accept only happens at cnt <= 24, so the shifted byte always fits.
    if (push_s) begin
      buf_n_s = buf_a_s | ({push_byte_s, 24'h000000} >> cnt_a_s);
      cnt_n_s = cnt_a_s + 6'd8;
    end else begin
      buf_n_s = buf_a_s;
      cnt_n_s = cnt_a_s;
    end
  end

  // Buffer, count, sticky error and the stuffing/marker state machine.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r         <= S_DATA;
      buf_r           <= 32'h0000_0000;
      cnt_r           <= 6'd0;
      marker_valid_r  <= 1'b0;
      marker_code_r   <= 8'h00;
      err_underflow_r <= 1'b0;
    end else begin
      buf_r <= buf_n_s;
      cnt_r <= cnt_n_s;
      if (consume && !cons_ok_s) begin
        err_underflow_r <= 1'b1;
      end
      case (state_r)
        S_DATA: begin
          if (accept_s && (in_data == 8'hFF)) begin
            state_r <= S_FF;
          end
        end
        S_FF: begin
          if (accept_s) begin
            if (in_data == 8'h00) begin
              state_r <= S_DATA;
            end else if (in_data == 8'hFF) begin
              state_r <= S_FF;
            end else begin
              marker_code_r  <= in_data;
              marker_valid_r <= 1'b1;
              state_r        <= S_MARK;
            end
          end
        end
        S_MARK: begin
          if (marker_ack && marker_valid_r) begin
            marker_valid_r <= 1'b0;
            state_r        <= S_DATA;
          end
        end
        default: begin
          state_r <= S_DATA;
        end
      endcase
    end
  end

  assign bits_window   = buf_r[31:16];
  assign bits_avail    = cnt_r;
  assign marker_valid  = marker_valid_r;
  assign marker_code   = marker_code_r;
  assign err_underflow = err_underflow_r;

endmodule

// File: tb/tb_jpeg_bit_unpacker.sv
// Directed, table-driven bench for jpeg_bit_unpacker with hand-computed expectations.
module tb_jpeg_bit_unpacker;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic [7:0]  in_data;
  logic        in_ready;
  logic [15:0] bits_window;
  logic [5:0]  bits_avail;
  logic        consume;
  logic [4:0]  consume_len;
  logic        align;
  logic        marker_valid;
  logic [7:0]  marker_code;
  logic        marker_ack;
  logic        err_underflow;

  int n_cmp;
  int n_bad;

  typedef struct {
    logic        iv;
    logic [7:0]  d;
    logic        c;
    logic [4:0]  cl;
    logic        al;
    logic        ack;
    logic [5:0]  e_avail;
    logic [15:0] e_win;
    logic        e_rdy;
    logic        e_mv;
    logic [7:0]  e_mc;
    logic        e_err;
  } vec_t;

  vec_t vq[$];

  jpeg_bit_unpacker dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
    .in_ready(in_ready), .bits_window(bits_window), .bits_avail(bits_avail),
    .consume(consume), .consume_len(consume_len), .align(align),
    .marker_valid(marker_valid), .marker_code(marker_code),
    .marker_ack(marker_ack), .err_underflow(err_underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [15:0] act, input logic [15:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got 0x%0h, expected 0x%0h", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic iv, input logic [7:0] d, input logic c, input logic [4:0] cl,
                     input logic al, input logic ack, input logic [5:0] ea, input logic [15:0] ew,
                     input logic er, input logic emv, input logic [7:0] emc, input logic ee);
    vec_t v;
    v = '{iv, d, c, cl, al, ack, ea, ew, er, emv, emc, ee};
    vq.push_back(v);
  endtask

  task automatic idle_inputs();
    in_valid = 1'b0; in_data = 8'h00; consume = 1'b0;
    consume_len = 5'd0; align = 1'b0; marker_ack = 1'b0;
  endtask

  task automatic chk_reset_outputs(input int idx);
    chk("rst_avail", idx, {10'd0, bits_avail}, 16'h0000);
    chk("rst_window", idx, bits_window, 16'h0000);
    chk("rst_mv", idx, {15'd0, marker_valid}, 16'h0000);
    chk("rst_mc", idx, {8'd0, marker_code}, 16'h0000);
    chk("rst_err", idx, {15'd0, err_underflow}, 16'h0000);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    idle_inputs();
    rst = 1'b1;
    #1;
    chk_reset_outputs(-1);
    chk("rst_ready", -1, {15'd0, in_ready}, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", -1, {15'd0, in_ready}, 16'h0001);

    // iv d c cl al ack | avail window ready mv mc err
    add(1'b1, 8'h12, 1'b0, 5'd0,  1'b0, 1'b0, 6'd8,  16'h1200, 1'b1, 1'b0, 8'h00, 1'b0);
    add(1'b1, 8'h34, 1'b0, 5'd0,  1'b0, 1'b0, 6'd16, 16'h1234, 1'b1, 1'b0, 8'h00, 1'b0);
    add(1'b0, 8'h00, 1'b1, 5'd4,  1'b0, 1'b0, 6'd12, 16'h2340, 1'b1, 1'b0, 8'h00, 1'b0);
    add(1'b0, 8'h00, 1'b1, 5'd12, 1'b0, 1'b0, 6'd0,  16'h0000, 1'b1, 1'b0, 8'h00, 1'b0);
    add(1'b1, 8'hFF, 1'b0, 5'd0,  1'b0, 1'b0, 6'd0,  16'h0000, 1'b1, 1'b0, 8'h00, 1'b0);
    add(1'b1, 8'h00, 1'b0, 5'd0,  1'b0, 1'b0, 6'd8,  16'hFF00, 1'b1, 1'b0, 8'h00, 1'b0);
    add(1'b1, 8'hAB, 1'b0, 5'd0,  1'b0, 1'b0, 6'd16, 16'hFFAB, 1'b1, 1'b0, 8'h00, 1'b0);
    add(1'b0, 8'h00, 1'b1, 5'd16, 1'b0, 1'b0, 6'd0,  16'h0000, 1'b1, 1'b0, 8'h00, 1'b0);
    add(1'b1, 8'hC3, 1'b0, 5'd0,  1'b0, 1'b0, 6'd8,  16'hC300, 1'b1, 1'b0, 8'h00, 1'b0);
    add(1'b1, 8'hFF, 1'b0, 5'd0,  1'b0, 1'b0, 6'd8,  16'hC300, 1'b1, 1'b0, 8'h00, 1'b0);
    add(1'b1, 8'hFF, 1'b0, 5'd0,  1'b0, 1'b0, 6'd8,  16'hC300, 1'b1, 1'b0, 8'h00, 1'b0);
    add(1'b1, 8'hD9, 1'b0, 5'd0,  1'b0, 1'b0, 6'd8,  16'hC300, 1'b0, 1'b1, 8'hD9, 1'b0);
    add(1'b1, 8'h55, 1'b0, 5'd0,  1'b0, 1'b0, 6'd8,  16'hC300, 1'b0, 1'b1, 8'hD9, 1'b0);
    add(1'b1, 8'h55, 1'b0, 5'd0,  1'b1, 1'b0, 6'd8,  16'hC300, 1'b0, 1'b1, 8'hD9, 1'b0);
    add(1'b1, 8'h55, 1'b1, 5'd3,  1'b1, 1'b0, 6'd0,  16'h0000, 1'b0, 1'b1, 8'hD9, 1'b0);
    add(1'b0, 8'h00, 1'b0, 5'd0,  1'b0, 1'b1, 6'd0,  16'h0000, 1'b1, 1'b0, 8'hD9, 1'b0);
    add(1'b1, 8'hA5, 1'b0, 5'd0,  1'b0, 1'b0, 6'd8,  16'hA500, 1'b1, 1'b0, 8'hD9, 1'b0);
    add(1'b1, 8'hA5, 1'b0, 5'd0,  1'b0, 1'b0, 6'd16, 16'hA5A5, 1'b1, 1'b0, 8'hD9, 1'b0);
    add(1'b1, 8'hA5, 1'b0, 5'd0,  1'b0, 1'b0, 6'd24, 16'hA5A5, 1'b1, 1'b0, 8'hD9, 1'b0);
    add(1'b1, 8'hA5, 1'b0, 5'd0,  1'b0, 1'b0, 6'd32, 16'hA5A5, 1'b0, 1'b0, 8'hD9, 1'b0);
    add(1'b1, 8'hA5, 1'b1, 5'd8,  1'b0, 1'b0, 6'd24, 16'hA5A5, 1'b1, 1'b0, 8'hD9, 1'b0);
    add(1'b1, 8'hA5, 1'b0, 5'd0,  1'b0, 1'b0, 6'd32, 16'hA5A5, 1'b0, 1'b0, 8'hD9, 1'b0);
    add(1'b0, 8'h00, 1'b1, 5'd4,  1'b0, 1'b0, 6'd28, 16'h5A5A, 1'b0, 1'b0, 8'hD9, 1'b0);
    add(1'b0, 8'h00, 1'b1, 5'd12, 1'b0, 1'b0, 6'd16, 16'hA5A5, 1'b1, 1'b0, 8'hD9, 1'b0);
    add(1'b1, 8'h3C, 1'b1, 5'd4,  1'b0, 1'b0, 6'd20, 16'h5A53, 1'b1, 1'b0, 8'hD9, 1'b0);
    add(1'b0, 8'h00, 1'b1, 5'd16, 1'b0, 1'b0, 6'd4,  16'hC000, 1'b1, 1'b0, 8'hD9, 1'b0);
    add(1'b0, 8'h00, 1'b1, 5'd4,  1'b0, 1'b0, 6'd0,  16'h0000, 1'b1, 1'b0, 8'hD9, 1'b0);
    add(1'b1, 8'hF8, 1'b0, 5'd0,  1'b0, 1'b0, 6'd8,  16'hF800, 1'b1, 1'b0, 8'hD9, 1'b0);
    add(1'b0, 8'h00, 1'b1, 5'd3,  1'b0, 1'b0, 6'd5,  16'hC000, 1'b1, 1'b0, 8'hD9, 1'b0);
    add(1'b0, 8'h00, 1'b1, 5'd6,  1'b0, 1'b0, 6'd5,  16'hC000, 1'b1, 1'b0, 8'hD9, 1'b1);
    add(1'b0, 8'h00, 1'b1, 5'd5,  1'b0, 1'b0, 6'd0,  16'h0000, 1'b1, 1'b0, 8'hD9, 1'b1);

    for (int i = 0; i < vq.size(); i++) begin
      in_valid = vq[i].iv; in_data = vq[i].d; consume = vq[i].c;
      consume_len = vq[i].cl; align = vq[i].al; marker_ack = vq[i].ack;
      @(posedge clk);
      #1;
      chk("avail", i, {10'd0, bits_avail}, {10'd0, vq[i].e_avail});
      chk("window", i, bits_window, vq[i].e_win);
      chk("in_ready", i, {15'd0, in_ready}, {15'd0, vq[i].e_rdy});
      chk("marker_valid", i, {15'd0, marker_valid}, {15'd0, vq[i].e_mv});
      chk("marker_code", i, {8'd0, marker_code}, {8'd0, vq[i].e_mc});
      chk("err", i, {15'd0, err_underflow}, {15'd0, vq[i].e_err});
    end

    // Reset while a marker is pending, then resume with a plain zero byte.
    idle_inputs();
    in_valid = 1'b1; in_data = 8'hFF;
    @(posedge clk); #1;
    in_data = 8'hE1;
    @(posedge clk); #1;
    chk("mark2_valid", 100, {15'd0, marker_valid}, 16'h0001);
    chk("mark2_code", 100, {8'd0, marker_code}, 16'h00E1);
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk_reset_outputs(101);
    chk("rst_ready", 101, {15'd0, in_ready}, 16'h0000);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("ready_after_rst", 102, {15'd0, in_ready}, 16'h0001);
    in_valid = 1'b1; in_data = 8'h00;
    @(posedge clk); #1;
    idle_inputs();
    chk("zero_avail", 103, {10'd0, bits_avail}, 16'h0008);
    chk("zero_window", 103, bits_window, 16'h0000);
    chk("zero_ready", 103, {15'd0, in_ready}, 16'h0001);

    // Reset in the middle of a stuffed pair drops the half-seen FF.
    in_valid = 1'b1; in_data = 8'hFF;
    @(posedge clk); #1;
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1; in_data = 8'h00;
    @(posedge clk); #1;
    idle_inputs();
    chk("ff_lost_avail", 104, {10'd0, bits_avail}, 16'h0008);
    chk("ff_lost_window", 104, bits_window, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/jpeg_bit_unpacker.md
# jpeg_bit_unpacker

Decoder-side entropy bitstream reader: accepts the byte-stuffed JPEG scan stream, strips stuffed 0x00 bytes after 0xFF, and detects markers. It presents an MSB-aligned bit window to the Huffman decoder, which consumes 0–16 bits per cycle. It is the receive counterpart of the encoder's bit packer/stuffer and sits between the byte input FIFO and the Huffman/run-length decoder.

## Interface
- No parameters. Buffer depth is fixed at 32 bits and the window width at 16 bits.
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  input byte valid.
- in_data  input  8  scan byte.
- in_ready  output  1  byte accepted when in_valid && in_ready.
- bits_window  output  16  next 16 stream bits. Bit 15 is the oldest bit. Positions at or beyond bits_avail read 0.
- bits_avail  output  6  valid bits buffered, 0..32.
- consume  input  1  remove consume_len bits this cycle.
- consume_len  input  5  0..16.
- align  input  1  discard bits_avail mod 8 bits (byte alignment before a marker or RST).
- marker_valid  output  1  marker detected; input is halted.
- marker_code  output  8  second byte of the marker (e.g. 0xD9).
- marker_ack  input  1  releases a marker and resumes input.
- err_underflow  output  1  sticky; set when consume_len > bits_avail.

## Operation
- Internal state: 32-bit shift buffer `buf` (MSB = oldest), count `cnt` 0..32, state machine S_DATA / S_FF / S_MARK.
- in_ready = !rst && state != S_MARK && cnt <= 24. It depends only on registered state, never on consume in the same cycle.
- S_DATA, byte accepted:
  - byte != 0xFF: append 8 bits at position cnt.
  - byte == 0xFF: append nothing; go to S_FF.
- S_FF, byte accepted:
  - 0x00: append 0xFF; go to S_DATA.
  - 0xFF: fill byte; append nothing; stay in S_FF.
  - any other value: marker_code <= byte, marker_valid <= 1; go to S_MARK.
- S_MARK: no input is accepted. Buffered bits stay readable and consumable.
  - marker_ack while marker_valid: marker_valid <= 0; go to S_DATA.
  - marker_ack in any other state is ignored.
- Consume, when consume && consume_len <= cnt: shift buf left by consume_len, cnt -= consume_len.
  - consume_len == 0 is a legal no-op.
  - If consume_len > cnt: no bits are removed and err_underflow <= 1. It stays set until rst.
- align: applied after that cycle's consume. Removes (cnt' mod 8) bits from the head, where cnt' is the count after consume.
- Push and consume in the same cycle: new cnt = cnt − consume_len + 8. Consumed bits are removed first; the new byte lands at position cnt − consume_len.
  - Max cnt is 32: accept requires cnt ≤ 24.
- Bits below cnt in buf are always zero (cleared on shift). bits_window = buf[31:16].

## Timing
- Reset values: cnt 0, buf 0, bits_window 0, bits_avail 0, state S_DATA, marker_valid 0, marker_code 0x00, err_underflow 0, in_ready 0 while rst is high.
- in_ready goes to 1 in the first cycle after rst deasserts.
- Latency: a byte accepted at edge N appears in bits_window/bits_avail after edge N.
  - A stuffed pair FF 00 appears only after the 00 is accepted.
  - marker_valid rises at the edge that accepts the marker code byte.
- consume/align take effect at the next edge. Outputs are registered.
- Sustained throughput: 1 byte/cycle, provided the consumer drains ≥ 8 bits/cycle on average.
- rst in any state, including S_FF or S_MARK, returns every register to its reset value immediately. A half-seen FF is lost.

## Test plan
- Stream 0x12 0x34, no consume → bits_avail 8 then 16, bits_window 0x1234. Consume 4 → window 0x2340, avail 12.
- Stream 0xFF 0x00 0xAB → after 0xFF, avail stays 0. Then window 0xFF00 with avail 8, then 0xFFAB with avail 16.
- Stream 0xC3 0xFF 0xFF 0xD9 → marker_valid 1, marker_code 0xD9, avail 8, in_ready 0. Next byte is held. align → avail 0. marker_ack → in_ready 1.
- Fill to 32 bits (4 bytes 0xA5) → in_ready 0 at cnt 32 and cnt 25..32. Consume 8 with in_valid high → byte accepted the next cycle, avail returns to 32 with no byte loss.
- cnt 5, consume 6 → err_underflow 1, avail stays 5. A further legal consume of 5 works, and err stays 1.
- Assert rst while in S_MARK → all outputs at reset values. Then stream 0x00 → avail 8, window 0x0000.
